// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer feeding the instruction decoder.
// Runs from Start to decoder Done, holds for stalls, redirects on taken branches.
module fetch_sequencer #(
  parameter int PC_W      = 10,
  parameter int STALL_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Done_in,
  input  logic             Stall_in,
  input  logic             Jen,
  input  logic             Taken,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  PC,
  output logic             Active,
  output logic             Hold,
  output logic             Ack,
  output logic             Overrun,
  output logic [CNT_W-1:0] CycleCnt
);

  localparam int SC_W = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;

  localparam logic [PC_W-1:0]  PC_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(STALL_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL,
    HALT
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic             ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    sc_d    = sc_q;
    ovr_d   = ovr_q;

    if ((state_q == RUN || state_q == STALL) &&
        cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (Start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (Done_in) begin
          state_d = HALT;
        end else if (Stall_in) begin
          state_d = STALL;
          sc_d    = SC_LOAD;
        end else if (Jen && Taken) begin
          pc_d = Target;
        end else if (pc_q == PC_MAX) begin
          state_d = HALT;
          ovr_d   = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      STALL: begin
        if (sc_q != '0) begin
          sc_d = sc_q - 1'b1;
        end else if (pc_q == PC_MAX) begin
          state_d = HALT;
          ovr_d   = 1'b1;
        end else begin
          state_d = RUN;
          pc_d    = pc_q + 1'b1;
        end
      end
      HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      sc_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      ovr_q   <= ovr_d;
    end
  end

  assign PC       = pc_q;
  assign Active   = (state_q == RUN) || (state_q == STALL);
  assign Hold     = (state_q == STALL);
  assign Ack      = (state_q == HALT);
  assign Overrun  = ovr_q;
  assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a wide instance and a
// narrow one (4-bit PC, 4-bit counter, 2 stall cycles).
module tb_fetch_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic       Done_in = 1'b0;
  logic       Stall_in = 1'b0;
  logic       Jen = 1'b0;
  logic       Taken = 1'b0;
  logic [9:0] Target = '0;

  logic [9:0]  pc_a;
  logic        act_a, hold_a, ack_a, ovr_a;
  logic [15:0] cnt_a;
  logic [3:0]  pc_b;
  logic        act_b, hold_b, ack_b, ovr_b;
  logic [3:0]  cnt_b;

  always #5 Clk = ~Clk;

  fetch_sequencer #(.PC_W(10), .STALL_CYC(1), .CNT_W(16)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .Done_in(Done_in), .Stall_in(Stall_in),
    .Jen(Jen), .Taken(Taken), .Target(Target),
    .PC(pc_a), .Active(act_a), .Hold(hold_a),
    .Ack(ack_a), .Overrun(ovr_a), .CycleCnt(cnt_a)
  );

  fetch_sequencer #(.PC_W(4), .STALL_CYC(2), .CNT_W(4)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .Done_in(Done_in), .Stall_in(Stall_in),
    .Jen(Jen), .Taken(Taken), .Target(Target[3:0]),
    .PC(pc_b), .Active(act_b), .Hold(hold_b),
    .Ack(ack_b), .Overrun(ovr_b), .CycleCnt(cnt_b)
  );

  typedef struct {
    bit    sel;
    string nm;
    int    pc;
    bit    act, hold, ack, ovr;
    int    cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   use_b = 1'b0;

  task automatic step(input string nm, input int pc,
                      input bit act, input bit hold,
                      input bit ack, input bit ovr,
                      input int cnt);
    exp_t e;
    @(posedge Clk);
    #1;
    e.sel = use_b; e.nm = nm; e.pc = pc;
    e.act = act; e.hold = hold; e.ack = ack;
    e.ovr = ovr; e.cnt = cnt;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    int   apc, acnt;
    bit   aact, ahold, aack, aovr;
    forever begin
      @(negedge Clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel) begin
          apc = int'(pc_b); acnt = int'(cnt_b);
          aact = act_b; ahold = hold_b;
          aack = ack_b; aovr = ovr_b;
        end else begin
          apc = int'(pc_a); acnt = int'(cnt_a);
          aact = act_a; ahold = hold_a;
          aack = ack_a; aovr = ovr_a;
        end
        n_chk++;
        if (apc != e.pc || acnt != e.cnt || aact != e.act ||
            ahold != e.hold || aack != e.ack || aovr != e.ovr) begin
          n_fail++;
          $display("FAIL %s: got pc=%0d act=%0d hold=%0d ack=%0d ovr=%0d cnt=%0d want pc=%0d act=%0d hold=%0d ack=%0d ovr=%0d cnt=%0d",
                   e.nm, apc, aact, ahold, aack, aovr, acnt,
                   e.pc, e.act, e.hold, e.ack, e.ovr, e.cnt);
        end
      end
    end
  end

  initial begin
    step("reset", 0, 0, 0, 0, 0, 0);
    Reset_n = 1'b1;
    step("idle", 0, 0, 0, 0, 0, 0);

    // straight line run, Done at PC=5
    Start = 1'b1;
    step("t2_start", 0, 1, 0, 0, 0, 0);
    Start = 1'b0;
    for (int i = 1; i <= 5; i++) step("t2_seq", i, 1, 0, 0, 0, i);
    Done_in = 1'b1;
    step("t2_done", 5, 0, 0, 1, 0, 6);
    Done_in = 1'b0;
    step("t2_halt", 5, 0, 0, 1, 0, 6);

    // stall and branches
    Start = 1'b1;
    step("t3_start", 0, 1, 0, 0, 0, 0);
    Start = 1'b0;
    step("t3_pc1", 1, 1, 0, 0, 0, 1);
    step("t3_pc2", 2, 1, 0, 0, 0, 2);
    Stall_in = 1'b1;
    step("t3_stall", 2, 1, 1, 0, 0, 3);
    Stall_in = 1'b0;
    step("t3_resume", 3, 1, 0, 0, 0, 4);
    Jen = 1'b1; Taken = 1'b0; Target = 10'd40;
    step("t4_nottaken", 4, 1, 0, 0, 0, 5);
    Taken = 1'b1; Target = 10'd3;
    step("t4_back", 3, 1, 0, 0, 0, 6);
    Target = 10'd40;
    step("t4_taken", 40, 1, 0, 0, 0, 7);
    Jen = 1'b0; Taken = 1'b0;
    Start = 1'b1;
    step("t6_start_run", 41, 1, 0, 0, 0, 8);
    Start = 1'b0;
    Done_in = 1'b1; Stall_in = 1'b1;
    Jen = 1'b1; Taken = 1'b1; Target = 10'd7;
    step("t6_prio", 41, 0, 0, 1, 0, 9);
    Done_in = 1'b0; Stall_in = 1'b0; Jen = 1'b0; Taken = 1'b0;
    step("t6_halt", 41, 0, 0, 1, 0, 9);

    // last-address branches, then overrun
    Start = 1'b1;
    step("ov_start", 0, 1, 0, 0, 0, 0);
    Start = 1'b0;
    Jen = 1'b1; Taken = 1'b1; Target = 10'd1022;
    step("ov_br1022", 1022, 1, 0, 0, 0, 1);
    Target = 10'd1023;
    step("ov_br1023", 1023, 1, 0, 0, 0, 2);
    Target = 10'd5;
    step("ov_brlast", 5, 1, 0, 0, 0, 3);
    Target = 10'd1023;
    step("ov_br1023b", 1023, 1, 0, 0, 0, 4);
    Jen = 1'b0; Taken = 1'b0;
    step("ov_halt", 1023, 0, 0, 1, 1, 5);
    step("ov_sticky", 1023, 0, 0, 1, 1, 5);
    Start = 1'b1;
    step("ov_restart", 0, 1, 0, 0, 0, 0);
    Start = 1'b0;
    Jen = 1'b1; Taken = 1'b1;
    step("ovs_br", 1023, 1, 0, 0, 0, 1);
    Jen = 1'b0; Taken = 1'b0; Stall_in = 1'b1;
    step("ovs_stall", 1023, 1, 1, 0, 0, 2);
    Stall_in = 1'b0;
    step("ovs_halt", 1023, 0, 0, 1, 1, 3);

    // reset mid-stall
    Start = 1'b1;
    step("t1_start", 0, 1, 0, 0, 0, 0);
    Start = 1'b0; Stall_in = 1'b1;
    step("t1_stall", 0, 1, 1, 0, 0, 1);
    Reset_n = 1'b0;
    step("t1_reset", 0, 0, 0, 0, 0, 0);
    Reset_n = 1'b1; Stall_in = 1'b0;
    step("t1_idle", 0, 0, 0, 0, 0, 0);

    // narrow instance: overrun, counter saturation, 2-cycle stall
    use_b = 1'b1;
    Start = 1'b1;
    step("t5_start", 0, 1, 0, 0, 0, 0);
    Start = 1'b0;
    for (int i = 1; i <= 15; i++) step("t5_seq", i, 1, 0, 0, 0, i);
    step("t5_overrun", 15, 0, 0, 1, 1, 15);
    Start = 1'b1;
    step("t5_restart", 0, 1, 0, 0, 0, 0);
    Start = 1'b0; Stall_in = 1'b1;
    step("b_stall1", 0, 1, 1, 0, 0, 1);
    Stall_in = 1'b0;
    step("b_stall2", 0, 1, 1, 0, 0, 2);
    step("b_resume", 1, 1, 0, 0, 0, 3);
    Done_in = 1'b1;
    step("b_done", 1, 0, 0, 1, 0, 4);
    Done_in = 1'b0;

    repeat (3) @(negedge Clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
